// File: rtl/encoder4to2_hs.sv
// Registered 4-to-2 priority encoder with valid/ack handshake and an accepted-code counter.
// Define ENC_DEBOUNCE_EN to add a DEBOUNCE state that requires STABLE_CNT stable cycles.
module encoder4to2_hs #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       ack,
  output logic       b0,
  output logic       b1,
  output logic       valid,
  output logic       multi,
  output logic [7:0] cnt
);

  localparam int unsigned REQ_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DB_W  = 4;

`ifdef ENC_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE, DEBOUNCE, VALID, RELEASE} state_t;
`else
  typedef enum logic [1:0] {IDLE, VALID, RELEASE} state_t;
`endif

  state_t           state;
  logic [REQ_W-1:0] s1;
  logic [REQ_W-1:0] s2;
  logic [1:0]       code_c;
  logic             multi_c;

`ifdef ENC_DEBOUNCE_EN
  logic [DB_W-1:0]  db_cnt;
  logic [REQ_W-1:0] db_val;
`else
  logic [DB_W-1:0]  unused_stable;
  assign unused_stable = DB_W'(STABLE_CNT);
`endif

  // Priority encode of the synchronized request vector; d3 wins.
  always_comb begin
    code_c = 2'b00;
    if (s2[3])      code_c = 2'b11;
    else if (s2[2]) code_c = 2'b10;
    else if (s2[1]) code_c = 2'b01;
    multi_c = (s2[3] & (s2[2] | s2[1] | s2[0])) |
              (s2[2] & (s2[1] | s2[0])) |
              (s2[1] & s2[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      state <= IDLE;
      b0    <= 1'b0;
      b1    <= 1'b0;
      valid <= 1'b0;
      multi <= 1'b0;
      cnt   <= '0;
`ifdef ENC_DEBOUNCE_EN
      db_cnt <= '0;
      db_val <= '0;
`endif
    end else begin
      s1 <= {d3, d2, d1, d0};
      s2 <= s1;
      case (state)
        IDLE: begin
          if (s2 != '0) begin
`ifdef ENC_DEBOUNCE_EN
            if (STABLE_CNT <= 1) begin
              {b0, b1} <= code_c;
              multi    <= multi_c;
              valid    <= 1'b1;
              state    <= VALID;
            end else begin
              db_val <= s2;
              db_cnt <= DB_W'(1);
              state  <= DEBOUNCE;
            end
`else
            {b0, b1} <= code_c;
            multi    <= multi_c;
            valid    <= 1'b1;
            state    <= VALID;
`endif
          end
        end
`ifdef ENC_DEBOUNCE_EN
        // A different nonzero vector restarts the stability count.
        DEBOUNCE: begin
          if (s2 == '0) begin
            state <= IDLE;
          end else if (s2 != db_val) begin
            db_val <= s2;
            db_cnt <= DB_W'(1);
          end else if ((db_cnt + DB_W'(1)) >= DB_W'(STABLE_CNT)) begin
            db_cnt   <= db_cnt + DB_W'(1);
            {b0, b1} <= code_c;
            multi    <= multi_c;
            valid    <= 1'b1;
            state    <= VALID;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
`endif
        VALID: begin
          if (ack) begin
            valid <= 1'b0;
            cnt   <= cnt + CNT_W'(1);
            state <= RELEASE;
          end
        end
        // Wait for all lines to drop so a held press is reported only once.
        RELEASE: begin
          if (s2 == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/encoder4to2_hs.md
# encoder4to2_hs

Registered 4-to-2 priority encoder with valid/ack handshake: the inverse of the team's 2-to-4 decoder. Takes four request lines d0..d3 (asynchronous to clk, e.g. buttons or decoder-style select lines) and returns their 2-bit code on b0 (MSB) and b1 (LSB), the same bit order the decoder consumes. Each press is reported once and held until the consumer acknowledges it. An 8-bit counter tracks accepted codes.

## Interface
- STABLE_CNT, 4: debounce length in clk cycles (1..15); only used when ENC_DEBOUNCE_EN is defined
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d0, d1, d2, d3  input  1 each  request lines, active-high; d3 highest priority
- ack  input  1  consumer accepts current code; sampled only while valid=1
- b0  output  1  code MSB (registered)
- b1  output  1  code LSB (registered)
- valid  output  1  code on b0/b1 is new and unacknowledged
- multi  output  1  more than one request line was active at capture
- cnt  output  8  number of acknowledged codes, modulo 256

## Operation
- The request vector {d3,d2,d1,d0} passes through a 2-flop synchronizer (s1, then s2). All decisions use s2.
- Priority encode of s2: d3→b0b1=11, d2→10, d1→01, d0→00. multi=1 if two or more bits of s2 are set.
- FSM states: IDLE, DEBOUNCE (macro only), VALID, RELEASE.
  - IDLE: s2==0 → stay. s2!=0 → capture code and multi; go to VALID (or DEBOUNCE with macro).
  - VALID: valid=1; b0, b1 and multi held regardless of input changes. ack=1 → RELEASE, cnt increments by 1 (255 wraps to 0).
  - RELEASE: valid=0; outputs keep last code. Stay until s2==0, then IDLE. A held line is never reported twice.
- In states other than VALID, ack is ignored and cnt does not change.
- Asynchronous reset, asserted at any time including mid-handshake, clears:
  - the synchronizer and the FSM, returning the FSM to IDLE
  - the debounce counter
  - the outputs: b0=0, b1=0, valid=0, multi=0, cnt=0
- After reset is released, a line still held high is reported as a new press.

## Timing
- A request vector set up before rising edge N is in s2 after edge N+1. valid rises after edge N+2. b0, b1 and multi are valid in the same cycle as valid.
- ack high at edge M while valid=1:
  - valid falls after edge M.
  - cnt updates after edge M.
- With valid=1 and ack held high continuously, valid stays high for exactly one cycle.
- If s2 is already 0 when RELEASE is entered, RELEASE lasts one cycle, and then IDLE. A new press therefore needs at least 2 cycles after the ack edge before it can be captured.
- No combinational path exists from any input to any output.

## Configuration
- ENC_DEBOUNCE_EN defined: IDLE moves to DEBOUNCE with a 4-bit counter set to 1 and the s2 value stored.
  - Each cycle where s2 equals the stored value and is nonzero, the counter increments.
  - If s2 changes to another nonzero value, the new value is stored and the counter restarts at 1.
  - If s2 becomes 0, the FSM returns to IDLE.
  - When the counter reaches STABLE_CNT, the stored value is captured and the FSM goes to VALID.
  - A press held stable from edge N raises valid after edge N+1+STABLE_CNT.
- ENC_DEBOUNCE_EN undefined: there is no DEBOUNCE state, the STABLE_CNT parameter has no effect, and latency is N+2.

## Test plan
- Reset mid-handshake:
  - Stimulus: reset, then d2=1 (macro off). Required: valid=1, b0b1=10, multi=0 two edges later.
  - Stimulus: rst_n driven low between edges. Required: all outputs 0 immediately, with no clock edge needed.
- One report per press: d1 held high, ack pulsed.
  - Required: cnt=1, valid=0, and no second valid while d1 stays high.
  - Stimulus: d1 released, then d0 pressed. Required: b0b1=00, valid=1.
- Priority: d0, d1 and d3 asserted together. Required: b0b1=11, multi=1.
- Held output and ignored ack:
  - Stimulus: ack pulsed while valid=0. Required: no effect and cnt unchanged.
  - Stimulus: d3 asserted during VALID of a d1 code. Required: b0b1 stays 01.
- Counter wrap: 256 press/ack cycles. Required: cnt returns to 0, and valid pulses exactly 256 times.
- ENC_DEBOUNCE_EN with STABLE_CNT=4:
  - Stimulus: a 3-cycle glitch on d2. Required: no valid.
  - Stimulus: d2 held from edge N. Required: valid after edge N+5.
  - Stimulus: d1 switches to d2 mid-count. Required: count restarts, and d2's code (10) is reported.
